mdr_mem_interface: RTL and testbench
====================================

// Module: mdr_mem_interface
// PURPOSE
//   Memory interface stage feeding the datapath bus: holds MAR and MDR, runs single-word
//   read/write transactions to external memory over a req/ack handshake.
//   Drives BusMuxIn_MDR (bus mux MDR input); loads MAR/MDR from BusMuxOut.
//   Control unit issues Read/Write pulses and waits on done.
// PARAMETERS
//   DATA_W   32  data width of bus, MDR, memory data
//   ADDR_W   9   memory word address width; MAR = BusMuxOut[ADDR_W-1:0]
//   TIMEOUT  15  max cycles waiting for mem_ack (only with MEM_TIMEOUT_EN), >=1
// PORTS
//   clk           in   1       clock, rising edge
//   clr           in   1       reset, asynchronous, active-low
//   BusMuxOut     in   DATA_W  datapath bus
//   MARin         in   1       load MAR from bus
//   MDRin         in   1       load MDR from bus
//   Read          in   1       start read pulse
//   Write         in   1       start write pulse
//   BusMuxIn_MDR  out  DATA_W  MDR contents to bus mux
//   mem_addr      out  ADDR_W  memory address (= MAR)
//   mem_wdata     out  DATA_W  memory write data (= MDR)
//   mem_req       out  1       transaction request
//   mem_we        out  1       1 = write, 0 = read; valid while mem_req
//   mem_rdata     in   DATA_W  memory read data, valid with mem_ack
//   mem_ack       in   1       memory completion, one cycle
//   busy          out  1       transaction in progress
//   done          out  1       one-cycle completion pulse
//   err           out  1       timeout flag
// BEHAVIOUR
//   Reset (clr=0): MAR, MDR, all outputs 0, state IDLE; immediate, even mid-transaction.
//   States: IDLE, RD, WR. busy=1 in RD/WR; mem_req=busy; mem_we=1 only in WR.
//   IDLE: Read=1 -> RD; else Write=1 -> WR (Read wins if both; Write dropped).
//     MARin loads MAR; MDRin loads MDR; load + Read/Write same edge: MAR/MDR
//     take new bus value first, transaction uses it.
//   RD: on edge with mem_ack=1: MDR<=mem_rdata, -> IDLE, done=1 next cycle only.
//   WR: mem_wdata=MDR held stable; on mem_ack -> IDLE, done pulse; MDR unchanged.
//   Latency: Read at edge 0 -> mem_req high after edge 0; ack at edge k -> MDR valid
//     and done high after edge k; min 2 edges Read->done.
//   While busy: Read, Write, MARin, MDRin ignored; MAR/MDR frozen.
//   mem_ack in IDLE ignored. err cleared when next Read/Write accepted.
//   BusMuxIn_MDR = MDR registered; no combinational path from mem_rdata.
// CONFIGURATION
//   MEM_TIMEOUT_EN defined: cycle counter in RD/WR; TIMEOUT edges without ack ->
//     abort to IDLE, mem_req drops, err=1 (sticky), done pulses, MDR unchanged.
//     Ack on the timeout edge wins (normal completion, err stays 0).
//   Undefined: no counter, wait indefinitely for ack, err tied 0.
// TESTING
//   1 Reset mid-RD: clr=0 while mem_req=1 -> mem_req, busy, MDR, done = 0 same cycle.
//   2 Read: MARin bus=0x0000_0042, Read; ack 3 cycles later, rdata=0xDEAD_BEEF
//     -> mem_addr=0x042, mem_we=0, MDR=0xDEAD_BEEF, one done pulse.
//   3 Write: MDRin bus=0x1234_5678, MARin 0x1FF, Write; ack
//     -> mem_we=1, wdata=0x1234_5678, addr=0x1FF until ack; MDR unchanged.
//   4 Read+Write same cycle, then MDRin=0xFFFF_FFFF while busy
//     -> read only; MDR ends = mem_rdata, not 0xFFFF_FFFF.
//   5 MEM_TIMEOUT_EN, TIMEOUT=15, no ack -> abort at edge 15, err=1, done pulse;
//     next Read clears err. Without macro: mem_req held 100 cycles, err=0.
//   6 Spurious mem_ack in IDLE -> no state change, no done, MDR unchanged.

Source files
------------

// File: rtl/mdr_mem_interface.sv
// MAR/MDR memory interface: single-word read/write over a req/ack handshake. Latency: req after the Read/Write edge, done one cycle after the ack edge.
// Backpressure: Read/Write/MARin/MDRin are ignored while busy. Optional MEM_TIMEOUT_EN aborts a transaction after TIMEOUT edges without ack.
module mdr_mem_interface #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    output logic [DATA_W-1:0] BusMuxIn_MDR,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_mar;
    logic [DATA_W-1:0]   r_mdr;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_accept;
    logic                w_timeout;
    logic                w_busy;

    assign w_busy = (r_state != S_IDLE);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // r_cnt holds the number of ack-less edges already spent in RD/WR
    assign w_timeout = w_busy && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (!w_busy) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_timeout && !mem_ack) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Read) begin
                    w_state_nxt = S_RD;
                    w_accept    = 1'b1;
                end else if (Write) begin
                    w_state_nxt = S_WR;
                    w_accept    = 1'b1;
                end
            end
            S_RD, S_WR: begin
                if (mem_ack || w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            // Loads in IDLE land on the same edge that accepts Read/Write,
            // so the transaction sees the freshly loaded MAR/MDR.
            if (r_state == S_IDLE) begin
                if (MARin) begin
                    r_mar <= BusMuxOut[ADDR_W-1:0];
                end
                if (MDRin) begin
                    r_mdr <= BusMuxOut;
                end
            end else if (r_state == S_RD && mem_ack) begin
                r_mdr <= mem_rdata;
            end
        end
    end

    assign busy         = w_busy;
    assign mem_req      = w_busy;
    assign mem_we       = (r_state == S_WR);
    assign mem_addr     = r_mar;
    assign mem_wdata    = r_mdr;
    assign BusMuxIn_MDR = r_mdr;
    assign done         = r_done;

endmodule

// File: tb/tb_mdr_mem_interface.sv
// Randomized transaction-level bench for mdr_mem_interface with a MAR/MDR/err reference model.
module tb_mdr_mem_interface;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] BusMuxOut;
    logic        MARin, MDRin, Read, Write;
    logic [31:0] BusMuxIn_MDR;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy, done, err;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0]  m_mar;
    logic [31:0] m_mdr;
    logic        m_err;

    always #5 clk = ~clk;

    mdr_mem_interface dut (
        .clk          (clk),
        .clr          (clr),
        .BusMuxOut    (BusMuxOut),
        .MARin        (MARin),
        .MDRin        (MDRin),
        .Read         (Read),
        .Write        (Write),
        .BusMuxIn_MDR (BusMuxIn_MDR),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MARin     = 1'b0;
        MDRin     = 1'b0;
        Read      = 1'b0;
        Write     = 1'b0;
        mem_ack   = 1'b0;
        BusMuxOut = $urandom;
        mem_rdata = $urandom;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_req"}, mem_req, 1'b0);
        check({tag, "_mdr"}, BusMuxIn_MDR, m_mdr);
        check({tag, "_addr"}, mem_addr, m_mar);
        check({tag, "_err"}, err, m_err);
    endtask

    // One full transaction; ack arrives on the (dly+1)-th edge after the start edge.
    task automatic run_tx(input bit rd, input bit wr, input logic [31:0] a_word,
                          input logic [31:0] wd, input logic [31:0] rdat,
                          input int dly, input bit same_edge, input bit noise);
        bit is_wr;
        is_wr = !rd && wr;
        if (same_edge) begin
            BusMuxOut = wd;
            MARin     = 1'b1;
            MDRin     = 1'b1;
            m_mar     = wd[8:0];
            m_mdr     = wd;
        end else begin
            BusMuxOut = a_word;
            MARin     = 1'b1;
            step();
            m_mar = a_word[8:0];
            idle_inputs();
            BusMuxOut = wd;
            MDRin     = 1'b1;
            step();
            m_mdr = wd;
            idle_inputs();
            check("load_addr", mem_addr, m_mar);
            check("load_mdr", BusMuxIn_MDR, m_mdr);
        end
        Read  = rd;
        Write = wr;
        step();
        idle_inputs();
        m_err = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_req", mem_req, 1'b1);
        check("start_we", mem_we, is_wr);
        check("start_addr", mem_addr, m_mar);
        check("start_wdata", mem_wdata, m_mdr);
        check("start_err", err, m_err);
        for (int i = 0; i < dly; i++) begin
            if (noise) begin
                BusMuxOut = 32'hFFFF_FFFF;
                MARin     = 1'b1;
                MDRin     = 1'b1;
                Read      = 1'($urandom);
                Write     = 1'($urandom);
            end
            step();
            idle_inputs();
            check("wait_busy", busy, 1'b1);
            check("wait_we", mem_we, is_wr);
            check("wait_addr", mem_addr, m_mar);
            check("wait_mdr", BusMuxIn_MDR, m_mdr);
            check("wait_done", done, 1'b0);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdat;
        step();
        idle_inputs();
        if (rd) m_mdr = rdat;
        check("end_done", done, 1'b1);
        check_idle("end");
        step();
        check("done_pulse", done, 1'b0);
        check_idle("after");
    endtask

    task automatic spurious_ack();
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        step();
        idle_inputs();
        check("spur_done", done, 1'b0);
        check_idle("spur");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b0;
        idle_inputs();
        m_mar = '0;
        m_mdr = '0;
        m_err = 1'b0;
        #12;
        check("rst_done", done, 1'b0);
        check_idle("rst");
        #5 clr = 1'b1;
        step();

        // Directed: basic read, write, read+write with busy-time noise
        run_tx(1'b1, 1'b0, 32'h0000_0042, 32'h0BAD_F00D, 32'hDEAD_BEEF, 2, 1'b0, 1'b0);
        run_tx(1'b0, 1'b1, 32'h0000_01FF, 32'h1234_5678, 32'hCAFE_0000, 2, 1'b0, 1'b0);
        run_tx(1'b1, 1'b1, 32'h0000_0077, 32'h0101_0101, 32'hA5A5_5A5A, 3, 1'b0, 1'b1);
        run_tx(1'b1, 1'b0, 32'h0, 32'h0000_0123, 32'h7654_3210, 0, 1'b1, 1'b0);
        spurious_ack();

        // Reset while a read is outstanding
        BusMuxOut = 32'h0000_0055;
        MARin     = 1'b1;
        Read      = 1'b1;
        step();
        idle_inputs();
        step();
        check("mid_req", mem_req, 1'b1);
        #2 clr = 1'b0;
        #1;
        m_mar = '0;
        m_mdr = '0;
        m_err = 1'b0;
        check("midrst_done", done, 1'b0);
        check_idle("midrst");
        #2 clr = 1'b1;
        step();
        check_idle("postrst");

`ifdef MEM_TIMEOUT_EN
        BusMuxOut = 32'h0000_0011;
        MARin     = 1'b1;
        Read      = 1'b1;
        step();
        m_mar = 9'h011;
        idle_inputs();
        for (int k = 1; k < 15; k++) begin
            step();
            check("to_busy", busy, 1'b1);
            check("to_err0", err, 1'b0);
        end
        step();
        m_err = 1'b1;
        check("to_done", done, 1'b1);
        check_idle("to_abort");
        step();
        check("to_done_pulse", done, 1'b0);
        check("to_sticky", err, 1'b1);
        run_tx(1'b1, 1'b0, 32'h22, 32'h0, 32'h1357_9BDF, 14, 1'b0, 1'b0);
`else
        BusMuxOut = 32'h0000_0011;
        MARin     = 1'b1;
        Read      = 1'b1;
        step();
        m_mar = 9'h011;
        idle_inputs();
        for (int k = 0; k < 100; k++) begin
            step();
            check("hold_req", mem_req, 1'b1);
            check("hold_err", err, 1'b0);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h2468_ACE0;
        step();
        idle_inputs();
        m_mdr = 32'h2468_ACE0;
        check("hold_done", done, 1'b1);
        check_idle("hold_end");
`endif

        for (int t = 0; t < 40; t++) begin
            bit rd, wr;
            rd = 1'($urandom);
            wr = rd ? 1'($urandom) : 1'b1;
            run_tx(rd, wr, $urandom, $urandom, $urandom, int'($urandom_range(0, 10)),
                   1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) spurious_ack();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
